// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: shared constants and types for the register command parser.
//   OP_*  : command opcodes on the rx byte stream
//   RSP_* : response codes on the tx byte stream
//   reg_cmd_state_t : parser FSM state encoding
package reg_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_DATA = 8'h44;  // 'D'
    localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } reg_cmd_state_t;

endpackage

// File: rtl/reg_resp_serializer.sv
// reg_resp_serializer: loads up to NB+1 response bytes (left-aligned, first
// byte in the top bits) and shifts them out on a valid/ready handshake.
//   clk, reset   : clock, async active-high reset
//   i_load       : load i_bytes / i_count (only while idle)
//   i_count      : number of bytes to emit (1..NB+1)
//   i_bytes      : response bytes, first byte at the MSB end
//   o_tx_data    : current byte, stable until accepted
//   o_tx_valid   : byte valid
//   i_tx_ready   : downstream accepts the byte
//   o_done       : high on the handshake of the final byte
module reg_resp_serializer #(
    parameter  int unsigned NB = 2,
    localparam int unsigned PW = (NB + 1) * 8,
    localparam int unsigned CW = $clog2(NB + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_count,
    input  logic [PW-1:0] i_bytes,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_done
);

    logic [PW-1:0] r_buf;
    logic [CW-1:0] r_left;
    logic          r_valid;
    logic          w_hs;

    assign w_hs       = r_valid & i_tx_ready;
    assign o_done     = w_hs && (r_left == CW'(1));
    assign o_tx_data  = r_buf[PW-1 -: 8];
    assign o_tx_valid = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_bytes;
            r_left  <= i_count;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_buf  <= r_buf << 8;
            r_left <= r_left - CW'(1);
            if (r_left == CW'(1)) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_parser.sv
// reg_cmd_parser: parses framed 'W'/'R' commands from an 8-bit rx stream,
// drives the register block write/read ports and returns 'K', 'D'+data or
// 'E' on the 8-bit tx stream.
//   clk, reset            : clock, async active-high reset
//   i_rx_data/valid, o_rx_ready : command byte stream
//   o_tx_data/valid, i_tx_ready : response byte stream
//   o_w_en/addr/value     : register block write port
//   o_r_en/addr, i_r_value/valid : register block read port
//   o_err                 : one-cycle pulse when an 'E' response is queued
module reg_cmd_parser
    import reg_cmd_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_w_en,
    output logic [AW-1:0]    o_w_addr,
    output logic [WIDTH-1:0] o_w_value,
    output logic             o_r_en,
    output logic [AW-1:0]    o_r_addr,
    input  logic [WIDTH-1:0] i_r_value,
    input  logic             i_r_valid,
    output logic             o_err
);

    localparam int unsigned NB  = WIDTH / 8;
    localparam int unsigned CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned SCW = $clog2(NB + 2);
    localparam int unsigned PW  = (NB + 1) * 8;

    reg_cmd_state_t   r_state;
    logic             r_rx_ready;
    logic             r_is_write;
    logic [7:0]       r_addr;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_data;
    logic             r_w_en;
    logic [AW-1:0]    r_w_addr;
    logic             r_r_en;
    logic [AW-1:0]    r_r_addr;
    logic             r_err;

    logic             w_rx_hs;
    logic             w_op_ok;
    logic             w_in_bad;
    logic             w_reg_bad;
    logic             w_last;
    logic             w_timeout;
    logic             w_load;
    logic             w_load_err;
    logic [SCW-1:0]   w_count;
    logic [PW-1:0]    w_payload;
    logic             w_done;

    assign w_rx_hs   = i_rx_valid & r_rx_ready;
    assign w_op_ok   = (i_rx_data == OP_WRITE) || (i_rx_data == OP_READ);
    assign w_in_bad  = {1'b0, i_rx_data} >= 9'(DEPTH);
    assign w_reg_bad = {1'b0, r_addr} >= 9'(DEPTH);
    assign w_last    = (r_cnt == CW'(NB - 1));
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    // Response load is decoded from the current state so the first tx byte
    // is valid on the cycle after the deciding event.
    always_comb begin
        w_load     = 1'b0;
        w_load_err = 1'b0;
        w_count    = SCW'(1);
        w_payload  = {RSP_ERR, {WIDTH{1'b0}}};
        case (r_state)
            ST_IDLE:  w_load_err = w_rx_hs && !w_op_ok;
            ST_ADDR:  w_load_err = w_rx_hs && !r_is_write && w_in_bad;
            ST_DATA:  w_load_err = w_rx_hs && w_last && w_reg_bad;
            ST_WRITE: begin
                w_load    = 1'b1;
                w_payload = {RSP_ACK, {WIDTH{1'b0}}};
            end
            ST_WAIT: begin
                if (i_r_valid) begin
                    w_load    = 1'b1;
                    w_count   = SCW'(NB + 1);
                    w_payload = {RSP_DATA, i_r_value};
                end else begin
                    w_load_err = w_timeout;
                end
            end
            default: ;
        endcase
        if (w_load_err) begin
            w_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_data     <= '0;
            r_w_en     <= 1'b0;
            r_w_addr   <= '0;
            r_r_en     <= 1'b0;
            r_r_addr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_w_en <= 1'b0;
            r_r_en <= 1'b0;
            r_err  <= w_load_err;
            case (r_state)
                ST_IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_rx_hs) begin
                        if (w_op_ok) begin
                            r_is_write <= (i_rx_data == OP_WRITE);
                            r_state    <= ST_ADDR;
                        end else begin
                            r_rx_ready <= 1'b0;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rx_hs) begin
                        r_addr <= i_rx_data;
                        if (r_is_write) begin
                            // Out-of-range writes still consume their data bytes.
                            r_cnt   <= '0;
                            r_state <= ST_DATA;
                        end else if (w_in_bad) begin
                            r_rx_ready <= 1'b0;
                            r_state    <= ST_RESP;
                        end else begin
                            r_rx_ready <= 1'b0;
                            r_r_en     <= 1'b1;
                            r_r_addr   <= i_rx_data[AW-1:0];
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rx_hs) begin
                        r_data <= (r_data << 8) | WIDTH'(i_rx_data);
                        if (w_last) begin
                            r_rx_ready <= 1'b0;
                            if (w_reg_bad) begin
                                r_state <= ST_RESP;
                            end else begin
                                r_w_en   <= 1'b1;
                                r_w_addr <= r_addr[AW-1:0];
                                r_state  <= ST_WRITE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_WRITE: r_state <= ST_RESP;
                ST_READ: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_r_valid || w_timeout) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (w_done) begin
                        r_rx_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    reg_resp_serializer #(.NB(NB)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_count    (w_count),
        .i_bytes    (w_payload),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (w_done)
    );

    assign o_rx_ready = r_rx_ready;
    assign o_w_en     = r_w_en;
    assign o_w_addr   = r_w_addr;
    assign o_w_value  = r_data;
    assign o_r_en     = r_r_en;
    assign o_r_addr   = r_r_addr;
    assign o_err      = r_err;

endmodule

// File: tb/tb_reg_cmd_parser.sv
module tb_reg_cmd_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_w_en;
    logic [4:0]  o_w_addr;
    logic [15:0] o_w_value;
    logic        o_r_en;
    logic [4:0]  o_r_addr;
    logic [15:0] i_r_value = '0;
    logic        i_r_valid = 1'b0;
    logic        o_err;

    always #5 clk = ~clk;

    reg_cmd_parser #(.WIDTH(16), .DEPTH(32), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_w_en     (o_w_en),
        .o_w_addr   (o_w_addr),
        .o_w_value  (o_w_value),
        .o_r_en     (o_r_en),
        .o_r_addr   (o_r_addr),
        .i_r_value  (i_r_value),
        .i_r_valid  (i_r_valid),
        .o_err      (o_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_ren = 0, n_ren_exp = 0, n_err = 0, n_err_exp = 0;

    logic [7:0]  exp_tx[$];
    logic [20:0] exp_w[$];
    logic [15:0] mem [32];
    logic        respond = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output.
    always @(negedge clk) begin : mon
        logic [7:0]  e;
        logic [20:0] ew;
        if (!reset) begin
            if (o_tx_valid && i_tx_ready) begin
                n_checks++;
                if (exp_tx.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: actual %02h required none", o_tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    if (o_tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: actual %02h required %02h", o_tx_data, e);
                    end
                end
            end
            if (o_w_en) begin
                n_checks++;
                if (exp_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_unexpected: actual addr %0h value %04h required none", o_w_addr, o_w_value);
                end else begin
                    ew = exp_w.pop_front();
                    if ({o_w_addr, o_w_value} !== ew) begin
                        n_fail++;
                        $display("FAIL w_strobe: actual %0h/%04h required %0h/%04h",
                                 o_w_addr, o_w_value, ew[20:16], ew[15:0]);
                    end
                end
            end
            if (o_r_en) n_ren++;
            if (o_err) begin
                n_err++;
                n_checks++;
                if (!(o_tx_valid === 1'b1 && o_tx_data === 8'h45)) begin
                    n_fail++;
                    $display("FAIL err_align: actual valid %b data %02h required 1/45", o_tx_valid, o_tx_data);
                end
            end
        end
    end

    // Register block model: answers a read strobe two cycles later.
    always @(negedge clk) begin : rsp
        logic [4:0] ra;
        if (!reset && o_r_en && respond) begin
            ra = o_r_addr;
            @(posedge clk);
            #1 i_r_value = mem[ra];
            i_r_valid = 1'b1;
            @(posedge clk);
            #1 i_r_valid = 1'b0;
            i_r_value = '0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t = 0;
        while (o_rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_timeout: byte %02h actual not accepted required accepted", b);
        end
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] v);
        if (a < 8'd32) begin
            exp_w.push_back({a[4:0], v});
            exp_tx.push_back(8'h4B);
            if (a != 8'd0) mem[a[4:0]] = v;
        end else begin
            exp_tx.push_back(8'h45);
            n_err_exp++;
        end
        send_byte(8'h57);
        send_byte(a);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic do_read(input logic [7:0] a);
        if (a < 8'd32) begin
            n_ren_exp++;
            if (respond) begin
                exp_tx.push_back(8'h44);
                exp_tx.push_back(mem[a[4:0]][15:8]);
                exp_tx.push_back(mem[a[4:0]][7:0]);
            end else begin
                exp_tx.push_back(8'h45);
                n_err_exp++;
            end
        end else begin
            exp_tx.push_back(8'h45);
            n_err_exp++;
        end
        send_byte(8'h52);
        send_byte(a);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_tx.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: actual %0d bytes pending required 0", name, exp_tx.size());
        end
        @(negedge clk);
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: actual simulation still running required finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin : main
        logic [7:0] held;
        logic       stable;
        int         t;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", o_rx_ready, 0);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_tx_data",  o_tx_data, 0);
        check("rst_w_en",     o_w_en, 0);
        check("rst_r_en",     o_r_en, 0);
        check("rst_err",      o_err, 0);
        check("rst_addrs",    {o_w_addr, o_r_addr, o_w_value}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", o_rx_ready, 1);

        // Write with strobe/ack timing
        do_write(8'h05, 16'h1234);
        check("wr_en_n1",   o_w_en, 1);
        check("wr_addr",    o_w_addr, 5);
        check("wr_value",   o_w_value, 16'h1234);
        @(negedge clk);
        check("wr_en_n2",   o_w_en, 0);
        check("wr_k_valid", o_tx_valid, 1);
        check("wr_k_data",  o_tx_data, 8'h4B);
        drain("wr");

        // Read with strobe/data timing
        do_read(8'h05);
        check("rd_en_n1", o_r_en, 1);
        @(negedge clk);
        check("rd_en_n2", o_r_en, 0);
        @(negedge clk);
        check("rd_d_valid", o_tx_valid, 1);
        check("rd_d_data",  o_tx_data, 8'h44);
        drain("rd");

        // Bad opcode
        exp_tx.push_back(8'h45);
        n_err_exp++;
        send_byte(8'h11);
        check("badop_valid", o_tx_valid, 1);
        check("badop_err",   o_err, 1);
        drain("badop");

        // Out-of-range and boundary addresses
        do_write(8'h40, 16'hAAAA);
        drain("wr_oor");
        do_read(8'h40);
        drain("rd_oor");
        do_read(8'h20);
        drain("rd_depth");
        do_write(8'h1F, 16'hBEEF);
        drain("wr_last");
        do_read(8'h1F);
        drain("rd_last");
        do_write(8'h00, 16'hFFFF);
        drain("wr_zero");

        // Read timeout, then a stray read-valid must be ignored
        respond = 1'b0;
        do_read(8'h07);
        repeat (15) @(negedge clk);
        check("to_early", o_tx_valid, 0);
        @(negedge clk);
        check("to_at", o_tx_valid, 1);
        drain("timeout");
        respond = 1'b1;
        i_r_valid = 1'b1;
        i_r_value = 16'h5555;
        @(negedge clk);
        i_r_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ignored", o_tx_valid, 0);

        // Backpressure in the middle of a 'D' response
        do_read(8'h1F);
        t = 0;
        while (o_tx_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_d_seen", o_tx_data, 8'h44);
        @(negedge clk);
        i_tx_ready = 1'b0;
        held = o_tx_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (o_tx_valid !== 1'b1 || o_tx_data !== held) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_byte", held, 8'hBE);
        i_tx_ready = 1'b1;
        drain("bp");

        // Reset in the middle of a write frame
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'hAA);
        reset = 1'b1;
        #1;
        check("midrst_rx_ready", o_rx_ready, 0);
        check("midrst_w_value",  o_w_value, 0);
        check("midrst_strobes",  {o_w_en, o_r_en, o_tx_valid, o_err}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_write(8'h03, 16'hCAFE);
        drain("post_rst_wr");
        do_read(8'h03);
        drain("post_rst_rd");

        check("tx_queue_empty", exp_tx.size(), 0);
        check("w_queue_empty",  exp_w.size(), 0);
        check("r_en_count",     n_ren, n_ren_exp);
        check("err_count",      n_err, n_err_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
